// File: rtl/vendo_multi.sv
// Multi-item vending controller: per-item prices and stock, 1/5-unit coins,
// coin-by-coin change, cancel and inactivity-timeout refunds, sold-out tracking.
module vendo_multi #(
    parameter int                        N_ITEMS    = 4,
    parameter int                        CRED_W     = 8,
    parameter logic [N_ITEMS*CRED_W-1:0] PRICES     = {8'd15, 8'd12, 8'd8, 8'd6},
    parameter int                        STOCK_W    = 4,
    parameter int                        STOCK_INIT = 3,
    parameter int                        TIMEOUT    = 64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_ITEMS-1:0] sel,
    input  logic               p_1,
    input  logic               p_5,
    input  logic               cancel,
    input  logic               restock,
    output logic [N_ITEMS-1:0] disp,
    output logic               chg_1,
    output logic               chg_5,
    output logic [CRED_W-1:0]  credit,
    output logic               busy,
    output logic [N_ITEMS-1:0] sold_out
);
    localparam int IDX_W = (N_ITEMS > 1) ? $clog2(N_ITEMS) : 1;
    localparam int TO_W  = $clog2(TIMEOUT) + 1;

    typedef enum logic [1:0] {IDLE, COLLECT, DISPENSE, CHANGE} state_t;

    state_t              state, state_n;
    logic [IDX_W-1:0]    idx, idx_n, sel_idx;
    logic [TO_W-1:0]     to_cnt, to_n;
    logic [CRED_W-1:0]   credit_n, sum, price, rem;
    logic [N_ITEMS-1:0]  disp_n;
    logic                chg_1_n, chg_5_n, coin, sel_ok, dec;
    logic [STOCK_W-1:0]  stock [N_ITEMS];

    // Returns {chg_5, chg_1, remaining credit} for one change coin.
    function automatic logic [CRED_W+1:0] take_coin(input logic [CRED_W-1:0] v);
        if (v >= CRED_W'(5)) return {1'b1, 1'b0, v - CRED_W'(5)};
        else                 return {1'b0, 1'b1, v - CRED_W'(1)};
    endfunction

    assign price  = PRICES[int'(idx)*CRED_W +: CRED_W];
    assign coin   = p_1 | p_5;
    assign sum    = credit + CRED_W'(p_1) + (p_5 ? CRED_W'(5) : CRED_W'(0));
    assign rem    = credit - price;
    assign sel_ok = (sel != '0) && ((sel & (sel - N_ITEMS'(1))) == '0);
    assign busy   = (state != IDLE);

    always_comb begin
        sel_idx = '0;
        for (int i = 0; i < N_ITEMS; i++) begin
            if (sel[i]) sel_idx = IDX_W'(i);
        end
    end

    always_comb begin
        for (int i = 0; i < N_ITEMS; i++) sold_out[i] = (stock[i] == '0);
    end

    // Output registers are loaded with the values for the state being entered,
    // so disp/chg pulses line up with the DISPENSE/CHANGE cycles.
    always_comb begin
        state_n  = state;
        idx_n    = idx;
        to_n     = to_cnt;
        credit_n = credit;
        disp_n   = '0;
        chg_1_n  = 1'b0;
        chg_5_n  = 1'b0;
        dec      = 1'b0;
        case (state)
            IDLE: begin
                if (sel_ok && !sold_out[sel_idx]) begin
                    state_n  = COLLECT;
                    idx_n    = sel_idx;
                    to_n     = '0;
                    credit_n = '0;
                end
            end
            COLLECT: begin
                credit_n = sum;
                to_n     = coin ? '0 : to_cnt + TO_W'(1);
                if (sum >= price) begin
                    state_n     = DISPENSE;
                    disp_n[idx] = 1'b1;
                end else if (cancel || (!coin && to_cnt == TO_W'(TIMEOUT - 1))) begin
                    if (sum == '0) begin
                        state_n = IDLE;
                    end else begin
                        state_n = CHANGE;
                        {chg_5_n, chg_1_n, credit_n} = take_coin(sum);
                    end
                end
            end
            DISPENSE: begin
                dec = 1'b1;
                if (rem == '0) begin
                    state_n  = IDLE;
                    credit_n = '0;
                end else begin
                    state_n = CHANGE;
                    {chg_5_n, chg_1_n, credit_n} = take_coin(rem);
                end
            end
            CHANGE: begin
                if (credit == '0) begin
                    state_n = IDLE;
                end else begin
                    {chg_5_n, chg_1_n, credit_n} = take_coin(credit);
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            idx    <= '0;
            to_cnt <= '0;
            credit <= '0;
            disp   <= '0;
            chg_1  <= 1'b0;
            chg_5  <= 1'b0;
        end else begin
            state  <= state_n;
            idx    <= idx_n;
            to_cnt <= to_n;
            credit <= credit_n;
            disp   <= disp_n;
            chg_1  <= chg_1_n;
            chg_5  <= chg_5_n;
        end
    end

    // Restock has priority over a same-cycle dispense decrement.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_ITEMS; i++) stock[i] <= STOCK_W'(STOCK_INIT);
        end else if (restock) begin
            for (int i = 0; i < N_ITEMS; i++) stock[i] <= STOCK_W'(STOCK_INIT);
        end else if (dec && stock[idx] != '0) begin
            stock[idx] <= stock[idx] - STOCK_W'(1);
        end
    end
endmodule

// File: tb/tb_vendo_multi.sv
// Self-checking bench for vendo_multi: table-driven purchases with a
// scoreboard queue, plus hand-written cancel, sold-out, timeout and reset cases.
module tb_vendo_multi;
    localparam int N       = 4;
    localparam int CW      = 8;
    localparam int TIMEOUT = 64;

    logic          clk     = 1'b0;
    logic          rst     = 1'b0;
    logic [N-1:0]  sel     = '0;
    logic          p_1     = 1'b0;
    logic          p_5     = 1'b0;
    logic          cancel  = 1'b0;
    logic          restock = 1'b0;
    logic [N-1:0]  disp;
    logic          chg_1, chg_5;
    logic [CW-1:0] credit;
    logic          busy;
    logic [N-1:0]  sold_out;

    vendo_multi dut (
        .clk(clk), .rst(rst), .sel(sel), .p_1(p_1), .p_5(p_5),
        .cancel(cancel), .restock(restock), .disp(disp), .chg_1(chg_1),
        .chg_5(chg_5), .credit(credit), .busy(busy), .sold_out(sold_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        int item;
        int n5;
        int n1;
        bit cxl;
        int exp_credit;
        int exp_disp;
        int exp_c5;
        int exp_c1;
    } vec_t;

    vec_t vecs[7];
    vec_t sb_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   disp_cnt[N];
    int   c1_cnt   = 0;
    int   c5_cnt   = 0;
    bit   c5_late  = 1'b0;
    bit   both     = 1'b0;

    always @(negedge clk) begin
        if (!rst) begin
            for (int i = 0; i < N; i++) if (disp[i]) disp_cnt[i]++;
            if (chg_1) c1_cnt++;
            if (chg_5) begin
                c5_cnt++;
                if (c1_cnt > 0) c5_late = 1'b1;
            end
            if (chg_1 && chg_5) both = 1'b1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        for (int i = 0; i < N; i++) disp_cnt[i] = 0;
        c1_cnt  = 0;
        c5_cnt  = 0;
        c5_late = 1'b0;
        both    = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n = 0;
        while (busy && n < budget) begin
            step();
            n++;
        end
        check(name, busy, 0);
    endtask

    task automatic run_vec(input vec_t v);
        vec_t e;
        clear_mon();
        sb_q.push_back(v);
        sel = N'(1) << v.item;
        step();
        sel = '0;
        check("sel_busy", busy, 1);
        for (int k = 0; k < v.n5; k++) begin p_5 = 1'b1; step(); p_5 = 1'b0; end
        for (int k = 0; k < v.n1; k++) begin p_1 = 1'b1; step(); p_1 = 1'b0; end
        check("credit_peak", credit, v.exp_credit);
        if (v.cxl) begin
            cancel = 1'b1;
            step();
            cancel = 1'b0;
        end else begin
            check("disp_lat", disp, (v.exp_disp != 0) ? (N'(1) << v.item) : N'(0));
            if (v.exp_c5 + v.exp_c1 > 0) begin
                step();
                check("first_chg", chg_1 | chg_5, 1);
            end
        end
        wait_idle("vec_idle", 40);
        e = sb_q.pop_front();
        check("disp_cnt", disp_cnt[e.item], e.exp_disp);
        check("chg5_cnt", c5_cnt, e.exp_c5);
        check("chg1_cnt", c1_cnt, e.exp_c1);
        check("chg_order", {30'd0, c5_late, both}, 0);
        check("credit_end", credit, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        //          item n5 n1 cxl peak disp c5 c1
        vecs[0] = '{0, 1, 0 + 1, 0, 6,  1, 0, 0};
        vecs[1] = '{1, 2, 0, 0, 10, 1, 0, 2};
        vecs[2] = '{3, 3, 0, 0, 15, 1, 0, 0};
        vecs[3] = '{2, 3, 0, 0, 15, 1, 0, 3};
        vecs[4] = '{3, 2, 1, 1, 11, 0, 2, 1};
        vecs[5] = '{2, 0, 0, 1, 0,  0, 0, 0};
        vecs[6] = '{0, 0, 6, 0, 6,  1, 0, 0};
        for (int i = 0; i < N; i++) disp_cnt[i] = 0;

        #1 rst = 1'b1;
        repeat (3) step();
        check("rst_credit", credit, 0);
        check("rst_busy", busy, 0);
        check("rst_disp", disp, 0);
        check("rst_chg", {chg_5, chg_1}, 0);
        check("rst_sold_out", sold_out, 0);
        rst = 1'b0;
        step();

        for (int i = 0; i < 7; i++) run_vec(vecs[i]);
        check("stock_left", sold_out, 4'b0000);

        // Both coins in one cycle, then cancel: 6 refunded as 5 then 1.
        clear_mon();
        sel = 4'b1000; step(); sel = '0;
        p_1 = 1'b1; p_5 = 1'b1; step(); p_1 = 1'b0; p_5 = 1'b0;
        check("dual_credit", credit, 6);
        cancel = 1'b1; step(); cancel = 1'b0;
        check("dual_chg5", {chg_5, chg_1}, 2'b10);
        step();
        check("dual_chg1", {chg_5, chg_1}, 2'b01);
        step();
        check("dual_idle", busy, 0);
        check("dual_nodisp", disp_cnt[3], 0);

        // Item 0 has one left: buy it, then it must refuse selection.
        run_vec(vecs[0]);
        check("so_flag", sold_out, 4'b0001);
        sel = 4'b0001; step(); sel = '0;
        check("so_sel_ignored", busy, 0);
        sel = 4'b0011; step(); sel = '0;
        check("multihot_ignored", busy, 0);
        p_5 = 1'b1; step(); p_5 = 1'b0;
        check("idle_coin", credit, 0);
        restock = 1'b1; step(); restock = 1'b0;
        check("restock_clear", sold_out, 4'b0000);
        for (int i = 0; i < 3; i++) run_vec(vecs[0]);
        check("restock_depth", sold_out, 4'b0001);
        restock = 1'b1; step(); restock = 1'b0;
        check("restock_again", sold_out, 4'b0000);

        // Timeout with one unit of credit.
        clear_mon();
        sel = 4'b0100; step(); sel = '0;
        p_1 = 1'b1; step(); p_1 = 1'b0;
        n = 0;
        while (!chg_1 && n < 100) begin step(); n++; end
        check("to_chg1", chg_1, 1);
        check("to_wait_lo", n >= TIMEOUT - 2, 1);
        check("to_wait_hi", n <= TIMEOUT + 2, 1);
        step();
        check("to_idle", busy, 0);
        check("to_c1_cnt", c1_cnt, 1);

        // Timeout with no credit: straight back to IDLE.
        clear_mon();
        sel = 4'b0100; step(); sel = '0;
        n = 0;
        while (busy && n < 100) begin step(); n++; end
        check("to0_idle", busy, 0);
        check("to0_wait", (n >= TIMEOUT - 2) && (n <= TIMEOUT + 2), 1);
        check("to0_nochg", c1_cnt + c5_cnt, 0);

        // Reset asserted during the first change cycle.
        clear_mon();
        sel = 4'b0010; step(); sel = '0;
        p_5 = 1'b1; step(); step(); p_5 = 1'b0;
        step();
        check("rst_pre_chg", chg_1, 1);
        #2 rst = 1'b1;
        #1;
        check("arst_credit", credit, 0);
        check("arst_chg", {chg_5, chg_1}, 0);
        check("arst_disp", disp, 0);
        check("arst_busy", busy, 0);
        step(); step();
        rst = 1'b0;
        step();
        run_vec(vecs[1]);
        run_vec(vecs[1]);
        check("rst_stock_two", sold_out, 4'b0000);
        run_vec(vecs[1]);
        check("rst_stock_three", sold_out, 4'b0010);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
